// File: rtl/bsram_reader.sv
// Streaming read client for bsram: turns an (addr, len) command into a
// valid/ready word stream, hiding the memory's 1-cycle read latency.
module bsram_reader #(
    parameter int WIDTH = 13
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_addr,
    input  logic [WIDTH:0]   cmd_len,
    output logic [WIDTH-1:0] mem_dout_addr,
    input  logic [15:0]      mem_dout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_data,
    output logic             out_last,
    output logic             busy
);

    // Handshakes: a transfer happens on a rising edge where valid && ready;
    // the producer holds data stable while valid && !ready.
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_rd_addr;
    logic [WIDTH:0]     r_iss_cnt;
    logic               r_infl;
    logic               r_infl_last;
    logic [1:0]         r_occ;
    logic [15:0]        r_head_data;
    logic               r_head_last;
    logic [15:0]        r_tail_data;
    logic               r_tail_last;

    logic               w_pop;
    logic               w_issue;
    logic               w_done;
    logic [2:0]         w_level;

    assign w_pop   = (r_occ != 2'd0) && out_ready;
    // Words already owed to the FIFO after this edge; issuing only when it
    // stays below 2 makes overflow impossible.
    assign w_level = {1'b0, r_occ} + {2'b00, r_infl} - {2'b00, w_pop};
    assign w_issue = (r_state == RUN) && (r_iss_cnt != '0) && (w_level < 3'd2);
    assign w_done  = w_pop && r_head_last;

    assign cmd_ready     = (r_state == IDLE);
    assign busy          = (r_state == RUN);
    assign mem_dout_addr = r_rd_addr;
    assign out_valid     = (r_occ != 2'd0);
    assign out_data      = r_head_data;
    assign out_last      = r_head_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_rd_addr   <= '0;
            r_iss_cnt   <= '0;
            r_infl      <= 1'b0;
            r_infl_last <= 1'b0;
            r_occ       <= 2'd0;
            r_head_data <= 16'h0000;
            r_head_last <= 1'b0;
            r_tail_data <= 16'h0000;
            r_tail_last <= 1'b0;
        end else begin
            if (r_state == IDLE) begin
                if (cmd_valid && (cmd_len != '0)) begin
                    r_state   <= RUN;
                    r_rd_addr <= cmd_addr;
                    r_iss_cnt <= cmd_len;
                end
            end else if (w_done) begin
                r_state <= IDLE;
            end

            if (w_issue) begin
                r_rd_addr <= r_rd_addr + WIDTH'(1);
                r_iss_cnt <= r_iss_cnt - (WIDTH+1)'(1);
            end
            r_infl      <= w_issue;
            r_infl_last <= w_issue && (r_iss_cnt == (WIDTH+1)'(1));

            // r_infl marks the cycle in which mem_dout holds the issued word.
            case ({r_infl, w_pop})
                2'b10: begin
                    if (r_occ == 2'd0) begin
                        r_head_data <= mem_dout;
                        r_head_last <= r_infl_last;
                    end else begin
                        r_tail_data <= mem_dout;
                        r_tail_last <= r_infl_last;
                    end
                    r_occ <= r_occ + 2'd1;
                end
                2'b01: begin
                    r_head_data <= r_tail_data;
                    r_head_last <= r_tail_last;
                    r_occ       <= r_occ - 2'd1;
                end
                2'b11: begin
                    if (r_occ == 2'd1) begin
                        r_head_data <= mem_dout;
                        r_head_last <= r_infl_last;
                    end else begin
                        r_head_data <= r_tail_data;
                        r_head_last <= r_tail_last;
                        r_tail_data <= mem_dout;
                        r_tail_last <= r_infl_last;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/bsram_reader.md
# bsram_reader

Streaming read client for the `bsram` block. It accepts a (start address, length) command and drives the memory's read port. It absorbs the memory's fixed 1-cycle read latency and delivers the words as a valid/ready stream with a last-word marker, at up to one word per cycle under backpressure. It sits between a `bsram` instance and any consumer of linear memory data, such as video scan-out or DMA-to-peripheral paths.

## Interface
Parameters:
- `WIDTH`, default 13: address width; must equal the `WIDTH` of the attached `bsram`.

Ports:
- `clk`  in  1  single clock for the whole block; all state changes on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  command accepted when `cmd_valid && cmd_ready`.
- `cmd_addr`  in  `WIDTH`  first word address.
- `cmd_len`  in  `WIDTH+1`  word count, 0..2^WIDTH.
- `mem_dout_addr`  out  `WIDTH`  to the `bsram` read address.
- `mem_dout`  in  16  from the `bsram` read data; valid one cycle after its address is presented.
- `out_valid`  out  1  stream word available.
- `out_ready`  in  1  consumer takes the word when `out_valid && out_ready`.
- `out_data`  out  16  stream word.
- `out_last`  out  1  high with the final word of a command.
- `busy`  out  1  a command is in progress.

## Operation
- State `IDLE`: `cmd_ready`=1, `busy`=0.
  - On acceptance with `cmd_len`≠0: load `rd_addr`←`cmd_addr`, `iss_cnt`←`cmd_len`, and go to `RUN`.
  - On acceptance with `cmd_len`=0: the command is consumed, no words are produced, and the block stays in `IDLE`.
- State `RUN`: `cmd_ready`=0, `busy`=1.
- `mem_dout_addr` is driven directly from `rd_addr`, which is a register. The block never drives the memory's write port.
- A cycle is an issue cycle when `iss_cnt`≠0 and (`occ` + `infl` − `pop`) < 2, where:
  - `occ` is the output FIFO occupancy (0..2);
  - `infl` is 1 if the previous cycle issued;
  - `pop` = `out_valid && out_ready`.
- On an issue cycle:
  - `rd_addr` increments modulo 2^WIDTH, so 2^WIDTH−1 wraps to 0.
  - `iss_cnt` decrements.
  - `infl` is set for the next cycle, and the entry is tagged last if `iss_cnt` was 1.
- When `infl`=1, `mem_dout` is written into the 2-entry FIFO together with its last tag.
- Head of the FIFO:
  - `out_data` and `out_last` come from the head register.
  - `out_valid` = (`occ`≠0).
  - `out_data` and `out_last` hold stable while `out_valid && !out_ready`.
- The FIFO can never overflow; this follows from the issue rule. A push and a pop in the same cycle leave `occ` unchanged.
- The transfer completes when the entry tagged last is popped. The state returns to `IDLE` on that edge, so `cmd_ready`=1 the following cycle.
- A `cmd_valid` asserted in the completing cycle is not accepted in that cycle.
- Memory coherence is governed by `bsram` semantics: a same-cycle external write to the address being read returns the old data.
- Reset (asynchronous, any time including mid-transfer):
  - state=`IDLE`;
  - `rd_addr`, `iss_cnt`, `infl`, `occ`, and the FIFO data/tags are cleared;
  - the in-progress transfer is abandoned with no further output.

## Timing
- Reset values: `cmd_ready`=1, `busy`=0, `mem_dout_addr`=0, `out_valid`=0, `out_data`=0, `out_last`=0.
- Command accepted at the edge ending cycle 0:
  - first address presented in cycle 1;
  - data in `mem_dout` in cycle 2, captured at the end of cycle 2;
  - `out_valid`=1 in cycle 3.
- First-word latency is therefore 3 cycles from acceptance.
- With `out_ready` held high, one word is delivered per cycle. An N-word command completes with `out_last` in cycle N+2, and `cmd_ready` returns in cycle N+3.
- Stalls:
  - With `out_ready`=0 the FIFO fills to 2 and issuing stops.
  - Issuing resumes in the same cycle `out_ready` returns high, because `pop` counts toward the issue rule. This gives no throughput bubble after a stall.
- `out_ready` feeds only register enables. No combinational path exists from any input to any output.

## Test plan
- **Basic stream.** Preload `bsram[10..13]` with 0xA000..0xA003, then command addr=10, len=4 with `out_ready`=1.
  - Required: `out_valid` is first high 3 cycles after acceptance, the words 0xA000..0xA003 appear on consecutive cycles, `out_last` is set only on 0xA003, and `cmd_ready` returns the cycle after.
- **Backpressure.** Same preload, len=4, with `out_ready` toggling 1,0,0,1,0,1,1…
  - Required: no word is dropped or duplicated, `out_data` is stable through every stall, and `occ` never exceeds 2.
  - Required: words are delivered on every cycle where `out_ready`=1 after the FIFO has filled.
- **Wrap and full length.** With WIDTH=4, command addr=14, len=16.
  - Required: addresses are read in the order 14, 15, 0, 1, …, 13, with 16 words and last on address 13.
- **Zero length.** Command len=0.
  - Required: no `out_valid`, `busy` stays 0, and `cmd_ready` stays 1. A following command len=1 at addr=5 yields one word with `out_last`=1.
- **Reset mid-transfer.** Command len=8 and pull `rst_n` low after 3 words have been delivered.
  - Required: all outputs go to their reset values immediately (asynchronously).
  - Required: after release, a new command addr=0, len=2 streams correctly with no stale words.
- **Back-to-back commands.** Hold `cmd_valid` high with a second command present during the first command's final pop.
  - Required: the second command is not accepted in the completing cycle, is accepted in the next cycle, and the two streams do not overlap.
